// File: rtl/multi_servo_controller_pkg.sv
`default_nettype none
// ============================================================================
// Module   : multi_servo_controller_pkg
// Brief    : Shared constants, parser state encodings and pulse-width helper.
// Revision : 1.0
// ============================================================================
package multi_servo_controller_pkg;

   localparam logic [7:0] c_HDR_BYTE = 8'hFF;

   localparam logic [1:0] c_ST_IDLE  = 2'd0;
   localparam logic [1:0] c_ST_CHAN  = 2'd1;
   localparam logic [1:0] c_ST_ANGLE = 2'd2;

   // Full 32-bit unsigned pulse width; callers truncate to the counter width.
   function automatic logic [31:0] angle_to_clks(input logic [7:0] angle,
                                                  input int        pulse_min,
                                                  input int        clks_per_deg);
      return 32'(pulse_min) + (32'(angle) * 32'(clks_per_deg));
   endfunction

endpackage
`default_nettype wire

// File: rtl/multi_servo_controller_if.sv
`default_nettype none
// ============================================================================
// Module   : multi_servo_controller_if
// Brief    : UART byte stream in, PWM and command status out.
// Revision : 1.0
// ============================================================================
interface multi_servo_controller_if #(
   parameter int NUM_CHANNELS = 4
);
   logic                    i_RX_DV;
   logic [7:0]              i_RX_Byte;
   logic [NUM_CHANNELS-1:0] o_Servo;
   logic                    o_Cmd_Valid;
   logic [3:0]              o_Cmd_Chan;
   logic [7:0]              o_Cmd_Angle;
   logic                    o_Pkt_Err;
   logic                    o_Busy;

   modport master (
      output i_RX_DV, i_RX_Byte,
      input  o_Servo, o_Cmd_Valid, o_Cmd_Chan, o_Cmd_Angle, o_Pkt_Err, o_Busy
   );

   modport slave (
      input  i_RX_DV, i_RX_Byte,
      output o_Servo, o_Cmd_Valid, o_Cmd_Chan, o_Cmd_Angle, o_Pkt_Err, o_Busy
   );
endinterface
`default_nettype wire

// File: rtl/multi_servo_controller_pwm_channel.sv
`default_nettype none
// ============================================================================
// Module   : multi_servo_controller_pwm_channel
// Brief    : One servo: target/current/compare registers, slew, PWM compare.
// Revision : 1.0
// ============================================================================
module multi_servo_controller_pwm_channel
   import multi_servo_controller_pkg::*;
#(
   parameter int CNT_W          = 10,
   parameter int PULSE_MIN_CLKS = 50_000,
   parameter int CLKS_PER_DEG   = 753,
   parameter int RESET_ANGLE    = 90,
   parameter int SLEW_STEP      = 0
) (
   input  logic             i_Clk,
   input  logic             i_Reset,
   input  logic             i_Wr_En,
   input  logic [7:0]       i_Angle,
   input  logic             i_Frame_Start,
   input  logic [CNT_W-1:0] i_Count,
   output logic             o_Pwm,
   output logic             o_Busy
);

   localparam logic [7:0]       c_RESET_ANGLE = 8'(RESET_ANGLE);
   localparam logic [7:0]       c_SLEW_STEP   = 8'(SLEW_STEP);
   localparam logic [CNT_W-1:0] c_RESET_CMP   =
      CNT_W'(angle_to_clks(c_RESET_ANGLE, PULSE_MIN_CLKS, CLKS_PER_DEG));

   logic [7:0]       r_target;
   logic [7:0]       r_current;
   logic [CNT_W-1:0] r_compare;
   logic             r_pwm;
   logic [7:0]       w_next_cur;

   // Step toward target by at most the slew limit; a zero limit means jump.
   always_comb begin
      w_next_cur = r_target;
      if (c_SLEW_STEP != 8'd0) begin
         if (r_target > r_current) begin
            if ((r_target - r_current) > c_SLEW_STEP)
               w_next_cur = r_current + c_SLEW_STEP;
         end else if (r_current > r_target) begin
            if ((r_current - r_target) > c_SLEW_STEP)
               w_next_cur = r_current - c_SLEW_STEP;
         end
      end
   end

   always_ff @(posedge i_Clk) begin
      if (i_Reset) begin
         r_target  <= c_RESET_ANGLE;
         r_current <= c_RESET_ANGLE;
         r_compare <= c_RESET_CMP;
         r_pwm     <= 1'b0;
      end else begin
         if (i_Wr_En)
            r_target <= i_Angle;
         // Compare only moves at the frame boundary, keeping every pulse whole.
         if (i_Frame_Start) begin
            r_current <= w_next_cur;
            r_compare <= CNT_W'(angle_to_clks(w_next_cur, PULSE_MIN_CLKS, CLKS_PER_DEG));
         end
         r_pwm <= (i_Count < r_compare);
      end
   end

   assign o_Pwm  = r_pwm;
   assign o_Busy = (r_current != r_target);

endmodule
`default_nettype wire

// File: rtl/multi_servo_controller.sv
`default_nettype none
// ============================================================================
// Module   : multi_servo_controller
// Brief    : 3-byte UART packet parser driving N frame-aligned servo PWM channels.
// Revision : 1.0
// ============================================================================
module multi_servo_controller
   import multi_servo_controller_pkg::*;
#(
   parameter int NUM_CHANNELS    = 4,
   parameter int PWM_PERIOD_CLKS = 303_030,
   parameter int PULSE_MIN_CLKS  = 50_000,
   parameter int CLKS_PER_DEG    = 753,
   parameter int MAX_ANGLE       = 180,
   parameter int RESET_ANGLE     = 90,
   parameter int SLEW_STEP       = 0,
   parameter int TIMEOUT_CLKS    = 1_000_000
) (
   input  logic                          i_Clk,
   input  logic                          i_Reset,
   multi_servo_controller_if.slave       bus
);

   localparam int         c_CNT_W     = $clog2(PWM_PERIOD_CLKS);
   localparam int         c_TO_W      = $clog2(TIMEOUT_CLKS + 1);
   localparam logic [7:0] c_MAX_ANGLE = 8'(MAX_ANGLE);

   if ((NUM_CHANNELS < 1) || (NUM_CHANNELS > 16)) begin : g_bad_chan_count
      $error("multi_servo_controller: NUM_CHANNELS must be 1..16");
   end
   if ((PULSE_MIN_CLKS + MAX_ANGLE * CLKS_PER_DEG) >= PWM_PERIOD_CLKS) begin : g_bad_timing
      $error("multi_servo_controller: widest pulse does not fit in the PWM frame");
   end

   logic [1:0]              r_state;
   logic [3:0]              r_chan;
   logic [c_TO_W-1:0]       r_idle_cnt;
   logic                    r_cmd_valid;
   logic [3:0]              r_cmd_chan;
   logic [7:0]              r_cmd_angle;
   logic                    r_pkt_err;
   logic [c_CNT_W-1:0]      r_frame_cnt;
   logic                    r_busy;

   logic                    w_chan_ok;
   logic                    w_angle_ok;
   logic                    w_accept;
   logic                    w_frame_start;
   logic [NUM_CHANNELS-1:0] w_wr_en;
   logic [NUM_CHANNELS-1:0] w_pwm;
   logic [NUM_CHANNELS-1:0] w_busy;

   // The header byte is never a legal angle, even if MAX_ANGLE were 255.
   assign w_chan_ok     = (32'(bus.i_RX_Byte) < 32'(NUM_CHANNELS));
   assign w_angle_ok    = (bus.i_RX_Byte <= c_MAX_ANGLE) && (bus.i_RX_Byte != c_HDR_BYTE);
   assign w_accept      = bus.i_RX_DV && (r_state == c_ST_ANGLE) && w_angle_ok;
   assign w_frame_start = (r_frame_cnt == '0);

   always_ff @(posedge i_Clk) begin
      if (i_Reset) begin
         r_state     <= c_ST_IDLE;
         r_chan      <= '0;
         r_idle_cnt  <= '0;
         r_cmd_valid <= 1'b0;
         r_cmd_chan  <= '0;
         r_cmd_angle <= '0;
         r_pkt_err   <= 1'b0;
      end else begin
         r_cmd_valid <= 1'b0;
         r_pkt_err   <= 1'b0;
         if (bus.i_RX_DV) begin
            r_idle_cnt <= '0;
            case (r_state)
               c_ST_IDLE: begin
                  if (bus.i_RX_Byte == c_HDR_BYTE)
                     r_state <= c_ST_CHAN;
               end
               c_ST_CHAN: begin
                  if (bus.i_RX_Byte == c_HDR_BYTE) begin
                     r_state <= c_ST_CHAN;
                  end else if (w_chan_ok) begin
                     r_chan  <= bus.i_RX_Byte[3:0];
                     r_state <= c_ST_ANGLE;
                  end else begin
                     r_pkt_err <= 1'b1;
                     r_state   <= c_ST_IDLE;
                  end
               end
               c_ST_ANGLE: begin
                  if (w_angle_ok) begin
                     r_cmd_valid <= 1'b1;
                     r_cmd_chan  <= r_chan;
                     r_cmd_angle <= bus.i_RX_Byte;
                  end else begin
                     r_pkt_err <= 1'b1;
                  end
                  r_state <= c_ST_IDLE;
               end
               default: r_state <= c_ST_IDLE;
            endcase
         end else if (r_state != c_ST_IDLE) begin
            // Abandon a packet whose next byte never arrives.
            if (r_idle_cnt == c_TO_W'(TIMEOUT_CLKS - 1)) begin
               r_pkt_err  <= 1'b1;
               r_state    <= c_ST_IDLE;
               r_idle_cnt <= '0;
            end else begin
               r_idle_cnt <= r_idle_cnt + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge i_Clk) begin
      if (i_Reset) begin
         r_frame_cnt <= '0;
         r_busy      <= 1'b0;
      end else begin
         if (r_frame_cnt == c_CNT_W'(PWM_PERIOD_CLKS - 1))
            r_frame_cnt <= '0;
         else
            r_frame_cnt <= r_frame_cnt + 1'b1;
         r_busy <= |w_busy;
      end
   end

   for (genvar k = 0; k < NUM_CHANNELS; k++) begin : g_chan
      assign w_wr_en[k] = w_accept && (r_chan == 4'(k));

      multi_servo_controller_pwm_channel #(
         .CNT_W          (c_CNT_W),
         .PULSE_MIN_CLKS (PULSE_MIN_CLKS),
         .CLKS_PER_DEG   (CLKS_PER_DEG),
         .RESET_ANGLE    (RESET_ANGLE),
         .SLEW_STEP      (SLEW_STEP)
      ) u_chan (
         .i_Clk         (i_Clk),
         .i_Reset       (i_Reset),
         .i_Wr_En       (w_wr_en[k]),
         .i_Angle       (bus.i_RX_Byte),
         .i_Frame_Start (w_frame_start),
         .i_Count       (r_frame_cnt),
         .o_Pwm         (w_pwm[k]),
         .o_Busy        (w_busy[k])
      );
   end

   assign bus.o_Servo     = w_pwm;
   assign bus.o_Cmd_Valid = r_cmd_valid;
   assign bus.o_Cmd_Chan  = r_cmd_chan;
   assign bus.o_Cmd_Angle = r_cmd_angle;
   assign bus.o_Pkt_Err   = r_pkt_err;
   assign bus.o_Busy      = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_multi_servo_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_multi_servo_controller
// Brief    : Directed bench: dut0 jumps straight to target, dut1 slews 10 deg/frame.
// Revision : 1.0
// ============================================================================
module tb_multi_servo_controller;

   logic clk;
   logic rst;
   int   checks   = 0;
   int   failures = 0;

   // Pulse monitor state: high-time of the last completed pulse and pulse count.
   int run0 [4];
   int width0 [4];
   int pcnt0 [4];
   int run1;
   int width1;
   int pcnt1;

   multi_servo_controller_if #(.NUM_CHANNELS(4)) bus0 ();
   multi_servo_controller_if #(.NUM_CHANNELS(4)) bus1 ();

   multi_servo_controller #(
      .NUM_CHANNELS(4), .PWM_PERIOD_CLKS(1000), .PULSE_MIN_CLKS(100), .CLKS_PER_DEG(2),
      .MAX_ANGLE(180), .RESET_ANGLE(90), .SLEW_STEP(0), .TIMEOUT_CLKS(50)
   ) dut0 (
      .i_Clk   (clk),
      .i_Reset (rst),
      .bus     (bus0)
   );

   multi_servo_controller #(
      .NUM_CHANNELS(4), .PWM_PERIOD_CLKS(1000), .PULSE_MIN_CLKS(100), .CLKS_PER_DEG(2),
      .MAX_ANGLE(180), .RESET_ANGLE(90), .SLEW_STEP(10), .TIMEOUT_CLKS(50)
   ) dut1 (
      .i_Clk   (clk),
      .i_Reset (rst),
      .bus     (bus1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (rst) begin
         for (int k = 0; k < 4; k++) run0[k] = 0;
         run1 = 0;
      end else begin
         for (int k = 0; k < 4; k++) begin
            if (bus0.o_Servo[k]) begin
               run0[k]++;
            end else if (run0[k] != 0) begin
               width0[k] = run0[k];
               pcnt0[k]++;
               run0[k] = 0;
            end
         end
         if (bus1.o_Servo[0]) begin
            run1++;
         end else if (run1 != 0) begin
            width1 = run1;
            pcnt1++;
            run1 = 0;
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Called at a negedge with DV low; returns at the negedge after the byte is sampled.
   task automatic send_byte(input int which, input logic [7:0] b);
      if (which == 0) begin
         bus0.i_RX_DV   = 1'b1;
         bus0.i_RX_Byte = b;
      end else begin
         bus1.i_RX_DV   = 1'b1;
         bus1.i_RX_Byte = b;
      end
      @(negedge clk);
      bus0.i_RX_DV = 1'b0;
      bus1.i_RX_DV = 1'b0;
   endtask

   task automatic wait_pulse(input int which, input int ch, input string tag);
      int start;
      int cur;
      bit done;
      start = (which == 0) ? pcnt0[ch] : pcnt1;
      done  = 1'b0;
      for (int i = 0; i < 2500; i++) begin
         @(negedge clk);
         cur = (which == 0) ? pcnt0[ch] : pcnt1;
         if (cur != start) begin
            done = 1'b1;
            break;
         end
      end
      if (!done) check({tag, "_timeout"}, 32'd0, 32'd1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired observed=running expected=finished");
      $fatal(1, "simulation watchdog");
   end

   initial begin
      rst            = 1'b1;
      bus0.i_RX_DV   = 1'b0;
      bus0.i_RX_Byte = 8'h00;
      bus1.i_RX_DV   = 1'b0;
      bus1.i_RX_Byte = 8'h00;
      repeat (3) @(negedge clk);

      // Reset state
      check("rst_servo",  32'(bus0.o_Servo), 32'd0);
      check("rst_valid",  32'(bus0.o_Cmd_Valid), 32'd0);
      check("rst_err",    32'(bus0.o_Pkt_Err), 32'd0);
      check("rst_busy",   32'(bus0.o_Busy), 32'd0);
      check("rst_chan",   32'(bus0.o_Cmd_Chan), 32'd0);
      check("rst_angle",  32'(bus0.o_Cmd_Angle), 32'd0);
      rst = 1'b0;

      // Reset angle 90 -> 100 + 90*2 = 280 clocks on every channel
      wait_pulse(0, 0, "first_pulse");
      for (int k = 0; k < 4; k++) check($sformatf("reset_width_ch%0d", k), 32'(width0[k]), 32'd280);
      check("reset_busy", 32'(bus0.o_Busy), 32'd0);

      // FF,02,B4 -> ch2 at 180 deg -> 460 clocks
      send_byte(0, 8'hFF);
      send_byte(0, 8'h02);
      send_byte(0, 8'hB4);
      check("t2_valid", 32'(bus0.o_Cmd_Valid), 32'd1);
      check("t2_chan",  32'(bus0.o_Cmd_Chan), 32'd2);
      check("t2_angle", 32'(bus0.o_Cmd_Angle), 32'd180);
      @(negedge clk);
      check("t2_valid_one_cycle", 32'(bus0.o_Cmd_Valid), 32'd0);
      wait_pulse(0, 2, "t2_a");
      wait_pulse(0, 2, "t2_b");
      check("t2_ch2_width", 32'(width0[2]), 32'd460);
      check("t2_ch0_width", 32'(width0[0]), 32'd280);
      check("t2_ch1_width", 32'(width0[1]), 32'd280);

      // Bad channel, stray byte in IDLE, illegal angle
      send_byte(0, 8'hFF);
      send_byte(0, 8'h05);
      check("t3_badchan_err", 32'(bus0.o_Pkt_Err), 32'd1);
      send_byte(0, 8'h10);
      check("t3_err_one_cycle", 32'(bus0.o_Pkt_Err), 32'd0);
      check("t3_idle_ignored", 32'(bus0.o_Cmd_Valid), 32'd0);
      send_byte(0, 8'hFF);
      send_byte(0, 8'h01);
      send_byte(0, 8'hB5);
      check("t3_badangle_err", 32'(bus0.o_Pkt_Err), 32'd1);
      check("t3_badangle_valid", 32'(bus0.o_Cmd_Valid), 32'd0);
      wait_pulse(0, 1, "t3_a");
      wait_pulse(0, 1, "t3_b");
      check("t3_ch1_unchanged", 32'(width0[1]), 32'd280);
      // 07 ignored, FF resyncs in CHAN
      send_byte(0, 8'h07);
      send_byte(0, 8'hFF);
      send_byte(0, 8'hFF);
      check("t3_resync_no_err", 32'(bus0.o_Pkt_Err), 32'd0);
      send_byte(0, 8'h01);
      send_byte(0, 8'h00);
      check("t3_valid", 32'(bus0.o_Cmd_Valid), 32'd1);
      check("t3_chan",  32'(bus0.o_Cmd_Chan), 32'd1);
      check("t3_angle", 32'(bus0.o_Cmd_Angle), 32'd0);
      wait_pulse(0, 1, "t3_c");
      wait_pulse(0, 1, "t3_d");
      check("t3_ch1_width", 32'(width0[1]), 32'd100);
      check("t3_ch2_kept", 32'(width0[2]), 32'd460);

      // Timeout 50 cycles after the last byte
      send_byte(0, 8'hFF);
      send_byte(0, 8'h01);
      repeat (49) @(negedge clk);
      check("t4_no_err_at_49", 32'(bus0.o_Pkt_Err), 32'd0);
      @(negedge clk);
      check("t4_err_at_50", 32'(bus0.o_Pkt_Err), 32'd1);
      @(negedge clk);
      check("t4_err_one_cycle", 32'(bus0.o_Pkt_Err), 32'd0);
      send_byte(0, 8'h00);
      check("t4_after_timeout_valid", 32'(bus0.o_Cmd_Valid), 32'd0);
      check("t4_after_timeout_err", 32'(bus0.o_Pkt_Err), 32'd0);

      // Slewed channel: 90 -> 0 in steps of 10, one step per frame
      wait_pulse(1, 0, "t5_align");
      send_byte(1, 8'hFF);
      send_byte(1, 8'h00);
      send_byte(1, 8'h00);
      check("t5_valid", 32'(bus1.o_Cmd_Valid), 32'd1);
      @(negedge clk);
      check("t5_busy_set", 32'(bus1.o_Busy), 32'd1);
      for (int i = 0; i < 9; i++) begin
         wait_pulse(1, 0, "t5_step");
         check($sformatf("t5_width_step%0d", i), 32'(width1), 32'(260 - 20 * i));
         check($sformatf("t5_busy_step%0d", i), 32'(bus1.o_Busy), (i < 8) ? 32'd1 : 32'd0);
      end

      // Command lands mid-pulse on ch3: current pulse keeps 280, next is 100
      for (int i = 0; i < 2500; i++) begin
         @(negedge clk);
         if (bus0.o_Servo[3] && run0[3] >= 145) break;
      end
      check("t6_in_pulse", 32'(bus0.o_Servo[3]), 32'd1);
      send_byte(0, 8'hFF);
      send_byte(0, 8'h03);
      send_byte(0, 8'h00);
      check("t6_valid", 32'(bus0.o_Cmd_Valid), 32'd1);
      check("t6_chan",  32'(bus0.o_Cmd_Chan), 32'd3);
      wait_pulse(0, 3, "t6_a");
      check("t6_width_same_frame", 32'(width0[3]), 32'd280);
      wait_pulse(0, 3, "t6_b");
      check("t6_width_next_frame", 32'(width0[3]), 32'd100);

      // Reset mid-packet: outputs drop, no error, partial packet gone
      send_byte(0, 8'hFF);
      rst = 1'b1;
      @(negedge clk);
      check("t6_rst_servo0", 32'(bus0.o_Servo), 32'd0);
      check("t6_rst_servo1", 32'(bus1.o_Servo), 32'd0);
      check("t6_rst_err", 32'(bus0.o_Pkt_Err), 32'd0);
      send_byte(0, 8'h01);
      check("t6_rst_dv_ignored", 32'(bus0.o_Cmd_Valid), 32'd0);
      rst = 1'b0;
      send_byte(0, 8'h00);
      send_byte(0, 8'h00);
      check("t6_post_rst_valid", 32'(bus0.o_Cmd_Valid), 32'd0);
      check("t6_post_rst_err", 32'(bus0.o_Pkt_Err), 32'd0);
      wait_pulse(0, 3, "t6_c");
      check("t6_post_rst_width", 32'(width0[3]), 32'd280);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
